draw_sequencer: RTL and testbench
=================================

// Module: draw_sequencer
// PURPOSE
//  Top-level drawing sequencer directly upstream of the VGA adapter. Starts the fillscreen
//  engine, waits for its done, then starts the circle engine. Muxes the active engine's
//  pixel stream onto the single adapter port and clips off-screen circle pixels.
//  Counts accepted pixels for debug readout.
// PARAMETERS
//  SCREEN_W   160  visible columns; x >= SCREEN_W is clipped
//  SCREEN_H   120  visible rows; y >= SCREEN_H is clipped
//  CNT_W      15   width of pixel_count (saturating)
// PORTS
//  clk          in   1      system clock (CLOCK_50)
//  rst_n        in   1      reset; asynchronous, active-low
//  start        in   1      request a full draw (fill, then circle); sampled in IDLE only
//  done         out  1      draw complete; held while start stays high
//  fs_start     out  1      start to fillscreen engine
//  fs_done      in   1      done from fillscreen engine
//  fs_x         in   8      fillscreen pixel x
//  fs_y         in   7      fillscreen pixel y
//  fs_colour    in   3      fillscreen pixel colour
//  fs_plot      in   1      fillscreen pixel valid
//  circ_start   out  1      start to circle engine
//  circ_done    in   1      done from circle engine
//  circ_x       in   8      circle pixel x (may exceed SCREEN_W-1)
//  circ_y       in   7      circle pixel y (may exceed SCREEN_H-1)
//  circ_colour  in   3      circle pixel colour
//  circ_plot    in   1      circle pixel valid
//  vga_x        out  8      adapter pixel x
//  vga_y        out  7      adapter pixel y
//  vga_colour   out  3      adapter pixel colour
//  vga_plot     out  1      adapter write enable
//  pixel_count  out  CNT_W  number of vga_plot=1 cycles in current/last draw
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; done, fs_start, circ_start, pixel_count = 0.
//   vga_x/vga_y/vga_colour/vga_plot = 0 (IDLE output values).
//  FSM, registered state, transitions on posedge clk:
//   IDLE   : all starts low, vga_* = 0. start=1 -> FILL.
//   FILL   : fs_start=1; vga_x/y/colour = fs_*; vga_plot = fs_plot.
//            fs_done=1 -> GAP.
//   GAP    : one cycle; fs_start=0, circ_start=0, vga_plot=0, vga_x/y/colour = 0.
//            Unconditionally -> CIRC. Lets fillscreen clear its done.
//   CIRC   : circ_start=1; vga_x/y/colour = circ_*.
//            vga_plot = circ_plot & (circ_x < SCREEN_W) & (circ_y < SCREEN_H).
//            circ_done=1 -> DONE.
//   DONE   : circ_start=0, done=1, vga_plot=0, vga_* = 0.
//            start=0 -> IDLE (done=0 next cycle).
//  Output timing and flags:
//   - fs_start, circ_start, done: decoded from registered state (Moore, no input paths).
//   - vga_*: zero-latency combinational mux; same-cycle pixel seen by adapter.
//   - Clip compare is unsigned.
//   - Bounds: x=159/y=119 pass; x=160 or y=120 dropped; colour still driven, plot low.
//  pixel_count:
//   - Cleared on IDLE->FILL; +1 each cycle vga_plot=1.
//   - Saturates at 2^CNT_W-1 (no wrap); holds value through DONE and IDLE.
//  Start-handshake rules:
//   - start dropped mid-FILL/GAP/CIRC: ignored; draw completes.
//   - In DONE with start already low: done=1 for exactly one cycle, then IDLE.
//   - start held high through DONE->IDLE return is impossible (DONE exits only on start=0).
//   - New draw requires start low for >=1 cycle in IDLE-exit path.
//  Spurious inputs:
//   - fs_done while not FILL: ignored. circ_done while not CIRC: ignored.
//   - fs_done and circ_done both high in FILL: FILL->GAP only.
//  Reset mid-operation: immediate return to IDLE; engine starts drop asynchronously.
// TESTING
//  1 reset: rst_n=0 -> state IDLE; done=0, fs_start=0, circ_start=0, vga_plot=0, pixel_count=0.
//  2 full run: model fills 160x120, circle 50 px on-screen.
//    -> fs_start high until fs_done; GAP plot=0 1 cycle; then circ_start.
//    -> done=1, pixel_count=19250.
//  3 clipping: circ_x=160,y=5 -> plot=0; x=159,y=119 -> plot=1; x=10,y=120 -> plot=0.
//  4 start dropped mid-FILL -> run completes; done high 1 cycle; next cycle IDLE, done=0.
//  5 rst_n=0 mid-CIRC -> circ_start=0, vga_plot=0 same cycle; restart gives count from 0.
//  6 saturation: CNT_W=4, feed 20 fill pixels -> pixel_count stops at 15.
//    fs_done in IDLE -> no transition.

Source files
------------

// File: rtl/draw_sequencer_if.sv
// ---------------------------------------------------------------------------
// draw_sequencer_if
//   Bundle of the pixel-engine handshakes and the VGA adapter pixel port that
//   surround the drawing sequencer.
//
//   Fillscreen engine : fs_start (to engine), fs_done, fs_x, fs_y, fs_colour,
//                       fs_plot (from engine)
//   Circle engine     : circ_start (to engine), circ_done, circ_x, circ_y,
//                       circ_colour, circ_plot (from engine)
//   VGA adapter       : vga_x, vga_y, vga_colour, vga_plot (to adapter)
//
//   master : the sequencer side (drives starts and the adapter port)
//   slave  : the engines/adapter side
// ---------------------------------------------------------------------------
interface draw_sequencer_if;
  logic       fs_start;
  logic       fs_done;
  logic [7:0] fs_x;
  logic [6:0] fs_y;
  logic [2:0] fs_colour;
  logic       fs_plot;

  logic       circ_start;
  logic       circ_done;
  logic [7:0] circ_x;
  logic [6:0] circ_y;
  logic [2:0] circ_colour;
  logic       circ_plot;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  modport master (
    output fs_start, circ_start,
    output vga_x, vga_y, vga_colour, vga_plot,
    input  fs_done, fs_x, fs_y, fs_colour, fs_plot,
    input  circ_done, circ_x, circ_y, circ_colour, circ_plot
  );

  modport slave (
    input  fs_start, circ_start,
    input  vga_x, vga_y, vga_colour, vga_plot,
    output fs_done, fs_x, fs_y, fs_colour, fs_plot,
    output circ_done, circ_x, circ_y, circ_colour, circ_plot
  );
endinterface

// File: rtl/draw_sequencer.sv
// ---------------------------------------------------------------------------
// draw_sequencer
//   Drawing sequencer sitting directly upstream of the VGA adapter. A draw
//   request runs the fillscreen engine to completion, idles one cycle so the
//   fillscreen engine can drop its done, then runs the circle engine. The
//   active engine's pixel stream is muxed onto the adapter port with zero
//   latency; circle pixels outside the visible area are clipped by forcing
//   vga_plot low while the coordinates and colour are still passed through.
//
//   Parameters
//     SCREEN_W : visible columns; x >= SCREEN_W is clipped
//     SCREEN_H : visible rows;    y >= SCREEN_H is clipped
//     CNT_W    : width of the saturating pixel counter
//
//   Ports
//     clk         : system clock
//     rst_n       : asynchronous active-low reset
//     start       : draw request, sampled in IDLE only
//     done        : draw complete, held until start drops
//     pixel_count : number of vga_plot=1 cycles in the current/last draw
//     bus         : engine handshakes and adapter pixel port (master side)
// ---------------------------------------------------------------------------
module draw_sequencer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int CNT_W    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              done,
  output logic [CNT_W-1:0]  pixel_count,
  draw_sequencer_if.master  bus
);

  localparam logic [7:0] X_LIM = 8'(SCREEN_W);
  localparam logic [6:0] Y_LIM = 7'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_GAP,
    S_CIRC,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic             fs_start_c;
  logic             circ_start_c;
  logic             done_c;
  logic [7:0]       vga_x_c;
  logic [6:0]       vga_y_c;
  logic [2:0]       vga_colour_c;
  logic             vga_plot_c;
  logic [CNT_W-1:0] cnt_q;

  // Unsigned bounds test; the last visible column/row still passes.
  function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
    return (x < X_LIM) && (y < Y_LIM);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- next state, Moore starts/done, combinational pixel mux ----
  always_comb begin
    state_d      = state_q;
    fs_start_c   = 1'b0;
    circ_start_c = 1'b0;
    done_c       = 1'b0;
    vga_x_c      = '0;
    vga_y_c      = '0;
    vga_colour_c = '0;
    vga_plot_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FILL;
      end
      S_FILL: begin
        fs_start_c   = 1'b1;
        vga_x_c      = bus.fs_x;
        vga_y_c      = bus.fs_y;
        vga_colour_c = bus.fs_colour;
        vga_plot_c   = bus.fs_plot;
        // circ_done arriving here is stray and deliberately not looked at.
        if (bus.fs_done) state_d = S_GAP;
      end
      S_GAP: begin
        // One dead cycle so the fillscreen engine sees fs_start low and
        // clears its done before the circle engine is launched.
        state_d = S_CIRC;
      end
      S_CIRC: begin
        circ_start_c = 1'b1;
        vga_x_c      = bus.circ_x;
        vga_y_c      = bus.circ_y;
        vga_colour_c = bus.circ_colour;
        vga_plot_c   = bus.circ_plot & on_screen(bus.circ_x, bus.circ_y);
        if (bus.circ_done) state_d = S_DONE;
      end
      S_DONE: begin
        done_c = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---- pixel counter: cleared on draw launch, holds after the draw ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      cnt_q <= '0;
    end else if (vga_plot_c) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign done           = done_c;
  assign pixel_count    = cnt_q;
  assign bus.fs_start   = fs_start_c;
  assign bus.circ_start = circ_start_c;
  assign bus.vga_x      = vga_x_c;
  assign bus.vga_y      = vga_y_c;
  assign bus.vga_colour = vga_colour_c;
  assign bus.vga_plot   = vga_plot_c;

endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [14:0] pixel_count;
  logic        start_s;
  logic        done_s;
  logic [3:0]  pixel_count_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  draw_sequencer_if bus ();
  draw_sequencer_if bus_s ();

  draw_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .done        (done),
    .pixel_count (pixel_count),
    .bus         (bus)
  );

  draw_sequencer #(.CNT_W(4)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_s),
    .done        (done_s),
    .pixel_count (pixel_count_s),
    .bus         (bus_s)
  );

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       plot;
    logic       exp_plot;
  } clip_vec_t;

  clip_vec_t clip_tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input logic fs, input logic cs, input logic d,
                                       input logic [7:0] x, input logic [6:0] y,
                                       input logic [2:0] c, input logic p);
    return {10'b0, fs, cs, d, x, y, c, p};
  endfunction

  function automatic logic [31:0] outs();
    return {10'b0, bus.fs_start, bus.circ_start, done, bus.vga_x, bus.vga_y,
            bus.vga_colour, bus.vga_plot};
  endfunction

  function automatic logic [31:0] outs_s();
    return {10'b0, bus_s.fs_start, bus_s.circ_start, done_s, bus_s.vga_x, bus_s.vga_y,
            bus_s.vga_colour, bus_s.vga_plot};
  endfunction

  task automatic clear_inputs();
    bus.fs_done = 0; bus.fs_x = 0; bus.fs_y = 0; bus.fs_colour = 0; bus.fs_plot = 0;
    bus.circ_done = 0; bus.circ_x = 0; bus.circ_y = 0; bus.circ_colour = 0; bus.circ_plot = 0;
    bus_s.fs_done = 0; bus_s.fs_x = 0; bus_s.fs_y = 0; bus_s.fs_colour = 0; bus_s.fs_plot = 0;
    bus_s.circ_done = 0; bus_s.circ_x = 0; bus_s.circ_y = 0; bus_s.circ_colour = 0;
    bus_s.circ_plot = 0;
  endtask

  // One complete draw on the main DUT. The expected picture is the schedule
  // the bench itself scripts: lf fill cycles (fs_done on the last), one gap,
  // lc circle cycles (circ_done on the last), then DONE. Stray dones are
  // injected where they must be ignored.
  task automatic do_run(input int lf, input int lc, input bit full, input int drop_at,
                        input string tag);
    int exp_cnt;
    int sat_cnt;
    logic [7:0] fx, cx;
    logic [6:0] fy, cy;
    logic [2:0] fc, cc;
    logic fp, cp, vis;
    logic [31:0] exp;
    exp_cnt = 0;
    start = 1'b1;
    #1;
    check({tag, " idle"}, outs(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    tick();
    for (int t = 0; t <= lf + lc; t++) begin
      if (full) begin
        fx = 8'(t % 160); fy = 7'(t / 160); fc = 3'(t); fp = 1'b1;
        cx = 8'(20 + t - lf); cy = 7'd60; cc = 3'(t + 1); cp = 1'b1;
      end else begin
        fx = 8'($urandom); fy = 7'($urandom); fc = 3'($urandom); fp = 1'($urandom);
        case ($urandom_range(0, 3))
          0: cx = 8'($urandom);
          1: cx = 8'($urandom_range(157, 162));
          default: cx = 8'($urandom_range(0, 159));
        endcase
        case ($urandom_range(0, 3))
          0: cy = 7'($urandom);
          1: cy = 7'($urandom_range(117, 122));
          default: cy = 7'($urandom_range(0, 119));
        endcase
        cc = 3'($urandom); cp = 1'($urandom);
      end
      bus.fs_x = fx; bus.fs_y = fy; bus.fs_colour = fc; bus.fs_plot = fp;
      bus.circ_x = cx; bus.circ_y = cy; bus.circ_colour = cc; bus.circ_plot = cp;
      bus.fs_done   = (t == lf - 1) || (t >= lf && $urandom_range(0, 3) == 0);
      bus.circ_done = (t == lf + lc) || (t <= lf && $urandom_range(0, 3) == 0);
      if (t == drop_at) start = 1'b0;
      #1;
      if (t == 0) check({tag, " cnt cleared"}, 32'(pixel_count), 32'd0);
      if (t < lf) begin
        exp = pack(1, 0, 0, fx, fy, fc, fp);
        exp_cnt += int'(fp);
      end else if (t == lf) begin
        exp = pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0);
      end else begin
        vis = cp && (int'(cx) < 160) && (int'(cy) < 120);
        exp = pack(0, 1, 0, cx, cy, cc, vis);
        exp_cnt += int'(vis);
      end
      check($sformatf("%s cyc%0d", tag, t), outs(), exp);
      tick();
    end
    clear_inputs();
    sat_cnt = (exp_cnt > 32767) ? 32767 : exp_cnt;
    #1;
    check({tag, " done"}, outs(), pack(0, 0, 1, 8'd0, 7'd0, 3'd0, 0));
    check({tag, " count"}, 32'(pixel_count), 32'(sat_cnt));
    if (start) begin
      for (int k = 0; k < 2; k++) begin
        tick();
        check({tag, " done held"}, outs(), pack(0, 0, 1, 8'd0, 7'd0, 3'd0, 0));
      end
      start = 1'b0;
      tick();
      check({tag, " back idle"}, outs(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    end else begin
      tick();
      check({tag, " done 1cyc"}, outs(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
      tick();
      check({tag, " stays idle"}, outs(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    end
    check({tag, " count hold"}, 32'(pixel_count), 32'(sat_cnt));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_vis;
    int lf, lc;

    clip_tbl[0] = '{x: 8'd160, y: 7'd5,   c: 3'd1, plot: 1'b1, exp_plot: 1'b0};
    clip_tbl[1] = '{x: 8'd159, y: 7'd119, c: 3'd2, plot: 1'b1, exp_plot: 1'b1};
    clip_tbl[2] = '{x: 8'd10,  y: 7'd120, c: 3'd3, plot: 1'b1, exp_plot: 1'b0};
    clip_tbl[3] = '{x: 8'd0,   y: 7'd0,   c: 3'd4, plot: 1'b1, exp_plot: 1'b1};
    clip_tbl[4] = '{x: 8'd255, y: 7'd127, c: 3'd5, plot: 1'b1, exp_plot: 1'b0};
    clip_tbl[5] = '{x: 8'd159, y: 7'd0,   c: 3'd6, plot: 1'b1, exp_plot: 1'b1};
    clip_tbl[6] = '{x: 8'd100, y: 7'd50,  c: 3'd7, plot: 1'b0, exp_plot: 1'b0};
    clip_tbl[7] = '{x: 8'd161, y: 7'd119, c: 3'd1, plot: 1'b1, exp_plot: 1'b0};

    // Reset
    rst_n = 1'b1; start = 1'b0; start_s = 1'b0;
    clear_inputs();
    #2 rst_n = 1'b0;
    tick(); tick();
    check("reset outs", outs(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    check("reset count", 32'(pixel_count), 32'd0);
    check("reset outs sat", outs_s(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    rst_n = 1'b1;
    tick();

    // Stray engine dones while idle must not start anything
    bus.fs_done = 1'b1; bus.circ_done = 1'b1; bus_s.fs_done = 1'b1;
    tick(); tick();
    check("idle fs_done", outs(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    check("idle fs_done sat", outs_s(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    clear_inputs();
    tick();

    // Full-screen fill plus a 50-pixel on-screen circle
    do_run(19200, 50, 1'b1, -1, "full");
    check("full count 19250", 32'(pixel_count), 32'd19250);
    tick();

    // Clipping table applied while the circle engine is active
    start = 1'b1;
    tick();
    bus.fs_done = 1'b1;
    tick();
    bus.fs_done = 1'b0;
    start = 1'b0;
    tick();
    n_vis = 0;
    for (int i = 0; i < 8; i++) begin
      bus.circ_x = clip_tbl[i].x; bus.circ_y = clip_tbl[i].y;
      bus.circ_colour = clip_tbl[i].c; bus.circ_plot = clip_tbl[i].plot;
      #1;
      check($sformatf("clip%0d", i), outs(),
            pack(0, 1, 0, clip_tbl[i].x, clip_tbl[i].y, clip_tbl[i].c, clip_tbl[i].exp_plot));
      n_vis += int'(clip_tbl[i].exp_plot);
      tick();
    end
    bus.circ_plot = 1'b0; bus.circ_done = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("clip done", outs(), pack(0, 0, 1, 8'd0, 7'd0, 3'd0, 0));
    check("clip count", 32'(pixel_count), 32'(n_vis));
    tick();
    check("clip idle", outs(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));

    // Randomized draws, half of them with start dropped mid-draw
    for (int r = 0; r < 10; r++) begin
      lf = $urandom_range(1, 40);
      lc = $urandom_range(1, 30);
      do_run(lf, lc, 1'b0, (r % 2 == 1) ? int'($urandom_range(0, lf + lc)) : -1,
             $sformatf("rnd%0d", r));
    end

    // Asynchronous reset in the middle of the circle phase
    start = 1'b1;
    tick();
    bus.fs_done = 1'b1;
    tick();
    bus.fs_done = 1'b0;
    tick();
    bus.circ_x = 8'd5; bus.circ_y = 7'd5; bus.circ_colour = 3'd2; bus.circ_plot = 1'b1;
    #1;
    check("mid circ plot", outs(), pack(0, 1, 0, 8'd5, 7'd5, 3'd2, 1));
    tick();
    rst_n = 1'b0;
    #1;
    check("async rst outs", outs(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    check("async rst count", 32'(pixel_count), 32'd0);
    start = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    tick();
    do_run(12, 9, 1'b0, -1, "post rst");

    // Saturating counter on the narrow instance
    start_s = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus_s.fs_x = 8'(i); bus_s.fs_y = 7'd3; bus_s.fs_colour = 3'd7; bus_s.fs_plot = 1'b1;
      #1;
      check($sformatf("sat cnt%0d", i), 32'(pixel_count_s), 32'((i > 15) ? 15 : i));
      tick();
    end
    bus_s.fs_plot = 1'b0; bus_s.fs_done = 1'b1;
    tick();
    bus_s.fs_done = 1'b0;
    tick();
    bus_s.circ_done = 1'b1;
    tick();
    bus_s.circ_done = 1'b0;
    #1;
    check("sat done", outs_s(), pack(0, 0, 1, 8'd0, 7'd0, 3'd0, 0));
    check("sat count", 32'(pixel_count_s), 32'd15);
    start_s = 1'b0;
    tick();
    check("sat idle", outs_s(), pack(0, 0, 0, 8'd0, 7'd0, 3'd0, 0));
    check("sat hold", 32'(pixel_count_s), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
